// File: rtl/wb_byte_master.sv
// wb_byte_master
//   Byte-stream to Wishbone classic bridge. Parses a command byte stream
//   (0x57 addr data = write, 0x52 addr = read), runs one 8-bit single
//   Wishbone cycle with an ack timeout, then returns a status byte and, for
//   reads, one data byte on a valid/ready response stream. Only one
//   transaction is ever in flight.
//
//   Status codes: 0x00 ok, 0xEE bus timeout, 0xFF unknown opcode.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_data/valid/ready    command byte stream (in)
//   rsp_data/valid/ready    response byte stream (out)
//   wb_adr_o/dat_o/dat_i    Wishbone address, write data, read data
//   wb_cyc_o/stb_o/we_o     Wishbone cycle, strobe, write enable
//   wb_ack_i                Wishbone acknowledge
//   busy                    high whenever the FSM is not idle
//   timeout_pulse           single-cycle pulse on a timeout abort
module wb_byte_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  input  logic       wb_ack_i,
  output logic       busy,
  output logic       timeout_pulse
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_TMO    = 8'hEE;
  localparam logic [7:0] ST_BADOP  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS,
    RSP_STAT,
    RSP_DATA
  } state_t;

  state_t           state;
  logic             is_write;
  logic [7:0]       stat_q;
  logic [7:0]       rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             cmd_take;
  logic             rsp_take;

  // cmd_ready/rsp_valid are the registered handshake outputs, so the
  // transfer conditions use them directly.
  assign cmd_take = cmd_valid && cmd_ready;
  assign rsp_take = rsp_valid && rsp_ready;

  // Saturating increment of the bus-cycle counter.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != CNT_MAX) cnt_inc = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      stat_q        <= 8'h00;
      rdata_q       <= 8'h00;
      cnt_q         <= '0;
      cmd_ready     <= 1'b0;
      rsp_data      <= 8'h00;
      rsp_valid     <= 1'b0;
      wb_adr_o      <= 8'h00;
      wb_dat_o      <= 8'h00;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_ready comes out of reset low and rises on the first
          // clock spent in IDLE.
          cmd_ready <= 1'b1;
          if (cmd_take) begin
            busy <= 1'b1;
            if (cmd_data == OP_WRITE || cmd_data == OP_READ) begin
              is_write <= (cmd_data == OP_WRITE);
              state    <= GET_ADDR;
            end else begin
              is_write  <= 1'b0;
              stat_q    <= ST_BADOP;
              rsp_data  <= ST_BADOP;
              rsp_valid <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= RSP_STAT;
            end
          end
        end

        GET_ADDR: begin
          if (cmd_take) begin
            wb_adr_o <= cmd_data;
            if (is_write) begin
              state <= GET_DATA;
            end else begin
              cmd_ready <= 1'b0;
              wb_cyc_o  <= 1'b1;
              wb_stb_o  <= 1'b1;
              wb_we_o   <= 1'b0;
              cnt_q     <= '0;
              state     <= BUS;
            end
          end
        end

        GET_DATA: begin
          if (cmd_take) begin
            wb_dat_o  <= cmd_data;
            cmd_ready <= 1'b0;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_we_o   <= 1'b1;
            cnt_q     <= '0;
            state     <= BUS;
          end
        end

        BUS: begin
          // Ack is tested first so an ack on the expiry cycle wins.
          if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            stat_q    <= ST_OK;
            rsp_data  <= ST_OK;
            rsp_valid <= 1'b1;
            if (!is_write) rdata_q <= wb_dat_i;
            state     <= RSP_STAT;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              wb_cyc_o      <= 1'b0;
              wb_stb_o      <= 1'b0;
              wb_we_o       <= 1'b0;
              stat_q        <= ST_TMO;
              rsp_data      <= ST_TMO;
              rsp_valid     <= 1'b1;
              rdata_q       <= 8'h00;
              timeout_pulse <= 1'b1;
              state         <= RSP_STAT;
            end
          end
        end

        RSP_STAT: begin
          if (rsp_take) begin
            // Reads return a data byte after ok/timeout status.
            if (!is_write && stat_q != ST_BADOP) begin
              rsp_data <= rdata_q;
              state    <= RSP_DATA;
            end else begin
              rsp_valid <= 1'b0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        RSP_DATA: begin
          if (rsp_take) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          wb_we_o   <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
module tb_wb_byte_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic       wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic       busy, timeout_pulse;

  always #5 clk = ~clk;

  wb_byte_master #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_ack_i(wb_ack_i), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  // Slave: acks in the same cycle strobe is seen, so stb lasts one cycle.
  // 0x10 = pattern_mode (r/w), 0x11 = id register reading 0x02.
  logic [7:0] mem [256];
  logic       ack_en;
  assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en;
  assign wb_dat_i = mem[wb_adr_o];

  int         stb_cnt, to_cnt;
  logic [7:0] last_adr, last_dat;
  logic       last_we;

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      stb_cnt++;
      last_adr = wb_adr_o;
      last_dat = wb_dat_o;
      last_we  = wb_we_o;
      if (wb_ack_i && wb_we_o) mem[wb_adr_o] = wb_dat_o;
    end
    if (timeout_pulse) to_cnt++;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: expected response bytes, popped by the monitor.
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", {24'h0, rsp_data}, 32'hFFFF_FFFF);
      else chk("rsp", {24'h0, rsp_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (busy || rsp_valid || exp_q.size() != 0) chk({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    logic [7:0] held;
    logic       stable, rdy_seen;
    int         n;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h11] = 8'h02;
    ack_en = 1'b1; cmd_data = 8'h00; cmd_valid = 1'b0; rsp_ready = 1'b1;
    stb_cnt = 0; to_cnt = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {25'h0, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, busy, cmd_ready, timeout_pulse}, 0);
    chk("reset_data", {8'h0, rsp_data, wb_adr_o, wb_dat_o}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write 0x01 to pattern_mode
    stb_cnt = 0; exp_q.push_back(8'h00);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h01);
    chk("wr_cyc_rise", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
    @(posedge clk); #1;
    chk("wr_rsp_latency", {31'h0, rsp_valid}, 1);
    wait_done("wr");
    chk("wr_stb_cnt", stb_cnt, 1);
    chk("wr_bus", {15'h0, last_we, last_adr, last_dat}, {15'h0, 1'b1, 8'h10, 8'h01});
    chk("wr_pattern_mode", {24'h0, mem[8'h10]}, 32'h01);

    // 2: read id register
    stb_cnt = 0; exp_q.push_back(8'h00); exp_q.push_back(8'h02);
    send_byte(8'h52); send_byte(8'h11);
    wait_done("rd");
    chk("rd_stb_cnt", stb_cnt, 1);
    chk("rd_bus", {23'h0, last_we, last_adr}, {23'h0, 1'b0, 8'h11});
    chk("rd_busy_low", {31'h0, busy}, 0);

    // 3: timeout on a silent slave
    ack_en = 1'b0; stb_cnt = 0; to_cnt = 0;
    exp_q.push_back(8'hEE); exp_q.push_back(8'h00);
    send_byte(8'h52); send_byte(8'h20);
    wait_done("tmo");
    chk("tmo_stb_cnt", stb_cnt, 64);
    chk("tmo_pulse_cnt", to_cnt, 1);
    ack_en = 1'b1;

    // 4: invalid opcode, then a normal read
    stb_cnt = 0; exp_q.push_back(8'hFF);
    send_byte(8'h41);
    wait_done("inv");
    chk("inv_no_cyc", stb_cnt, 0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_byte(8'h52); send_byte(8'h10);
    wait_done("inv_rd");
    chk("inv_rd_stb", {stb_cnt[23:0], last_adr}, {24'h1, 8'h10});

    // 5: backpressure in RSP_STAT
    rsp_ready = 1'b0; exp_q.push_back(8'h00);
    send_byte(8'h57); send_byte(8'h12); send_byte(8'hAA);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_rsp_valid", {31'h0, rsp_valid}, 1);
    held = rsp_data; stable = 1'b1; rdy_seen = 1'b0; stb_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_data !== held || !rsp_valid) stable = 1'b0;
      if (cmd_ready) rdy_seen = 1'b1;
    end
    chk("bp_stable", {31'h0, stable}, 1);
    chk("bp_cmd_ready_low", {31'h0, rdy_seen}, 0);
    chk("bp_no_bus", stb_cnt, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done("bp");

    // 6: async reset while strobe is high
    ack_en = 1'b0;
    send_byte(8'h52); send_byte(8'h20);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pre_stb", {31'h0, wb_stb_o}, 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_bus", {28'h0, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid}, 0);
    @(negedge clk); rst_n = 1'b1; ack_en = 1'b1;
    @(posedge clk); #1;
    stb_cnt = 0; exp_q.push_back(8'h00);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h03);
    wait_done("post_rst_wr");
    chk("post_rst_wr", {stb_cnt[23:0], mem[8'h10]}, {24'h1, 8'h03});
    exp_q.push_back(8'h00); exp_q.push_back(8'h03);
    send_byte(8'h52); send_byte(8'h10);
    wait_done("post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
